// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between a gate-pair tester and its environment.
// slave: the checker itself; master: whoever starts runs and returns gate outputs.
interface truth_table_checker_if;
    logic       start;
    logic       x;
    logic       y;
    logic       a_in;
    logic       b_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [3:0] fail_vec;
    logic [1:0] first_fail_idx;
    logic       first_fail_valid;

    modport slave (
        input  start, a_in, b_in,
        output x, y, busy, done, pass, err_count, fail_vec,
               first_fail_idx, first_fail_valid
    );

    modport master (
        output start, a_in, b_in,
        input  x, y, busy, done, pass, err_count, fail_vec,
               first_fail_idx, first_fail_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps {x,y} through 00..11 and checks f_a = ~x&y, f_b = ~x|~y against observed
// gate outputs, accumulating a saturating error count and per-vector fail flags.
//
// state | meaning
// IDLE  | x=y=0, results held, waiting for start
// RUN   | driving vec_idx on {x,y}, sampling after SETTLE_CYCLES
// DONE  | one-cycle done pulse, pass valid
module truth_table_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t     state, state_nx;
    logic [1:0] vec_idx, vec_nx;
    logic [3:0] settle_cnt, settle_nx;
    logic [7:0] pass_cnt, pass_cnt_nx;
    logic [7:0] err_count, err_nx;
    logic [3:0] fail_vec, fail_nx;
    logic [1:0] ffi, ffi_nx;
    logic       ffv, ffv_nx;
    logic       pass_r, pass_nx;
    logic       x_q, y_q, a_exp, b_exp, mismatch;

    // Stimulus is a pure function of registered state, so reset clears it at once.
    assign x_q      = (state == RUN) & vec_idx[1];
    assign y_q      = (state == RUN) & vec_idx[0];
    assign a_exp    = ~x_q & y_q;
    assign b_exp    = ~x_q | ~y_q;
    assign mismatch = (bus.a_in != a_exp) || (bus.b_in != b_exp);

    assign bus.x                = x_q;
    assign bus.y                = y_q;
    assign bus.busy             = (state == RUN);
    assign bus.done             = (state == DONE);
    assign bus.pass             = pass_r;
    assign bus.err_count        = err_count;
    assign bus.fail_vec         = fail_vec;
    assign bus.first_fail_idx   = ffi;
    assign bus.first_fail_valid = ffv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec_idx    <= 2'd0;
            settle_cnt <= 4'd0;
            pass_cnt   <= 8'd0;
            err_count  <= 8'd0;
            fail_vec   <= 4'd0;
            ffi        <= 2'd0;
            ffv        <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            state      <= state_nx;
            vec_idx    <= vec_nx;
            settle_cnt <= settle_nx;
            pass_cnt   <= pass_cnt_nx;
            err_count  <= err_nx;
            fail_vec   <= fail_nx;
            ffi        <= ffi_nx;
            ffv        <= ffv_nx;
            pass_r     <= pass_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        vec_nx      = vec_idx;
        settle_nx   = settle_cnt;
        pass_cnt_nx = pass_cnt;
        err_nx      = err_count;
        fail_nx     = fail_vec;
        ffi_nx      = ffi;
        ffv_nx      = ffv;
        pass_nx     = pass_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    err_nx      = 8'd0;
                    fail_nx     = 4'd0;
                    ffi_nx      = 2'd0;
                    ffv_nx      = 1'b0;
                    pass_nx     = 1'b0;
                    vec_nx      = 2'd0;
                    settle_nx   = 4'd0;
                    pass_cnt_nx = 8'd0;
                    state_nx    = RUN;
                end
            end
            RUN: begin
                if (settle_cnt != SETTLE_LAST) begin
                    settle_nx = settle_cnt + 4'd1;
                end else begin
                    if (mismatch) begin
                        if (err_count != 8'hFF) err_nx = err_count + 8'd1;
                        fail_nx[vec_idx] = 1'b1;
                        if (!ffv) begin
                            ffi_nx = vec_idx;
                            ffv_nx = 1'b1;
                        end
                    end
                    settle_nx = 4'd0;
                    vec_nx    = vec_idx + 2'd1;
                    if (vec_idx == 2'd3) begin
                        pass_cnt_nx = pass_cnt + 8'd1;
                        if (pass_cnt == PASS_LAST) begin
                            state_nx = DONE;
                            // Include this edge's final sample in the verdict.
                            pass_nx  = (err_count == 8'd0) && !mismatch;
                        end
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule
